// File: rtl/alu_op_sequencer_pkg.sv
// Shared opcode and state encodings for the ALU operation sequencer and its
// iterative divider.
package alu_op_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_DIV     = 3'd3,
    OP_EQ      = 3'd4,
    OP_GT      = 3'd5,
    OP_LT      = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DIV_ITER = 8;
  localparam int ITER_W   = 4;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle between the instruction logic (master) and
// the ALU operation sequencer (slave).
interface alu_op_sequencer_if #(
  parameter int DATA_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [DATA_W-1:0]     req_a;
  logic [DATA_W-1:0]     req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [2*DATA_W-1:0]   res_data;
  logic                  res_zero;
  logic                  res_err;

  modport master (
    output req_valid, req_op, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_zero, res_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_zero, res_err
  );
endinterface

// File: rtl/alu_iter_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first; done
// pulses for one cycle once quotient/remainder are final.
module alu_iter_divider
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [ITER_W-1:0] cnt_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W:0]   shifted;
  logic              take;
  logic [DATA_W-1:0] rem_next;

  // Partial remainder is shifted one bit wider so it can exceed the divisor.
  always_comb begin
    shifted  = {rem_q, quo_q[DATA_W-1]};
    take     = (shifted >= {1'b0, dvs_q});
    rem_next = take ? DATA_W'(shifted - {1'b0, dvs_q}) : shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        cnt_q <= ITER_W'(DIV_ITER);
        quo_q <= dividend;
        rem_q <= '0;
        dvs_q <= divisor;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - ITER_W'(1);
        quo_q <= {quo_q[DATA_W-2:0], take};
        rem_q <= rem_next;
        done  <= (cnt_q == ITER_W'(1));
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// One-at-a-time sequencer for the 8-bit arithmetic cells: latches a request,
// computes it (single cycle or iterative divide) and holds the result.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  localparam int RES_W = 2 * DATA_W;

  state_e              state_q, state_d;
  op_e                 op_p0;
  logic [DATA_W-1:0]   a_p0, b_p0;
  logic [RES_W-1:0]    res_data_p1;
  logic                res_zero_p1, res_err_p1;
  logic                accept, div_go, div_done;
  logic [DATA_W-1:0]   div_quo, div_rem;
  logic [RES_W:0]      exec_word;
  logic                load_res;
  logic [RES_W-1:0]    res_next;
  logic                err_next;

  // Result of every single-cycle op, packed as {err, data}.
  function automatic logic [RES_W:0] exec_result(input op_e op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [RES_W-1:0] wa, wb;
    wa = {{DATA_W{1'b0}}, a};
    wb = {{DATA_W{1'b0}}, b};
    case (op)
      OP_ADD:  exec_result = {1'b0, {DATA_W{1'b0}}, DATA_W'(a + b)};
      OP_SUB:  exec_result = {1'b0, {DATA_W{1'b0}}, DATA_W'(a - b)};
      OP_MUL:  exec_result = {1'b0, RES_W'(wa * wb)};
      OP_EQ:   exec_result = {1'b0, RES_W'(a == b)};
      OP_GT:   exec_result = {1'b0, RES_W'(a > b)};
      OP_LT:   exec_result = {1'b0, RES_W'(a < b)};
      default: exec_result = {1'b1, {RES_W{1'b0}}};
    endcase
  endfunction

  assign accept = (state_q == ST_IDLE) && bus.req_valid;
  assign div_go = accept && (op_e'(bus.req_op) == OP_DIV) && (bus.req_b != '0);

  alu_iter_divider #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_go),
    .dividend  (bus.req_a),
    .divisor   (bus.req_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = div_go ? ST_DIV : ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: if (bus.res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exec_word = exec_result(op_p0, a_p0, b_p0);
    load_res  = 1'b0;
    res_next  = exec_word[RES_W-1:0];
    err_next  = exec_word[RES_W];
    if (state_q == ST_EXEC) begin
      load_res = 1'b1;
    end else if (state_q == ST_DIV && div_done) begin
      load_res = 1'b1;
      res_next = {div_rem, div_quo};
      err_next = 1'b0;
    end
  end

  // p0: operands captured at the accept edge, untouched until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0 <= op_e'(bus.req_op);
      a_p0  <= bus.req_a;
      b_p0  <= bus.req_b;
    end
  end

  // p1: registered result, held for the consumer while in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_count    <= '0;
      res_data_p1 <= '0;
      res_zero_p1 <= 1'b0;
      res_err_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DONE && bus.res_ready) op_count <= op_count + CNT_W'(1);
      if (load_res) begin
        res_data_p1 <= res_next;
        res_zero_p1 <= (res_next == '0);
        res_err_p1  <= err_next;
      end
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.res_data  = res_data_p1;
  assign bus.res_zero  = res_zero_p1;
  assign bus.res_err   = res_err_p1;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequencing controller for the 8-bit arithmetic cell set: add, subtract, multiply, divide and compare.
- Accepts one operation request at a time over a valid/ready handshake and latches the operands.
- Dispatches single-cycle ops to the combinational cells; runs divide through an iterative restoring divider.
- Holds the registered result until the consumer takes it. Sits between the top-level instruction/IO logic and the arithmetic cells.

Parameters:
DATA_W, 8, operand width; the cells are 8-bit, so only 8 is supported.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 EQ, 5 GT, 6 LT, 7 illegal
req_a  input  DATA_W  operand a
req_b  input  DATA_W  operand b
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  2*DATA_W  result
res_zero  output  1  res_data == 0
res_err  output  1  divide-by-zero or illegal opcode
busy  output  1  state != IDLE
op_count  output  CNT_W  completed result handshakes, wraps

Behaviour:
Clock and reset:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE, req_ready=1, res_valid=0, res_data=0, res_zero=0, res_err=0, busy=0, op_count=0, divider cleared.

State machine:
- IDLE: req_ready=1. On req_valid, latch op/a/b at the same edge (accept edge N).
  - Ops 0,1,2,4,5,6,7, and DIV with b==0 -> EXEC.
  - DIV with b!=0 -> DIV.
- EXEC: one cycle. Compute the result from the latched operands, register it at edge N+1, go to DONE. Single-cycle latency: res_valid is high from edge N+1.
- DIV: the divider runs 8 iterations, one quotient bit per cycle, MSB first. Result registered and state -> DONE at edge N+9, so res_valid is high from edge N+9.
- DONE: res_valid=1. res_data, res_zero and res_err are held stable while res_ready=0. On res_ready, go to IDLE and increment op_count (255 -> 0 wrap).
- req_ready=0 in every state except IDLE. A request presented while busy is not accepted and must be held by the requester.
- Earliest next accept is the cycle after the result handshake; there is no overlap.

Result formats:
- ADD/SUB: res_data = {8'h00, (a±b) mod 256}. No carry or borrow flag.
- MUL: res_data = a*b as a full 16-bit value.
- DIV: res_data = {remainder, quotient}.
- DIV with b==0: res_data=0, res_err=1, via EXEC with 1-cycle latency.
- EQ/GT/LT: res_data = {15'b0, flag}, unsigned compare.
- Opcode 7: res_data=0, res_err=1.
- res_zero is computed from the final res_data, including error cases, so it is 1 whenever res_err=1.

Boundary and exceptional conditions:
- Inputs req_* are ignored outside IDLE; latched operands are immune to later input changes.
- rst asserted mid-EXEC, mid-DIV or in DONE: the result is discarded and the next state is IDLE with reset values. op_count is reset as well.
- res_ready high while res_valid=0 has no effect.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_LT, OP_ILLEGAL), state encoding constants, DIV_ITER=8.
- One sub-module, alu_iter_divider:
  - Inputs: start, dividend, divisor.
  - Outputs: done pulse, quotient, remainder.
  - Internals: 4-bit iteration counter, clear on rst.
- ADD/SUB/MUL/compare logic instantiates the existing sum, minus, multiply and compare cells combinationally from the latched operands.

Test Plan:
1. After reset: res_valid=0, req_ready=1, op_count=0. Then ADD a=200, b=100 -> one cycle later res_data=16'h002C, res_zero=0, res_err=0.
2. MUL a=255, b=255 with res_ready held low 5 cycles -> res_data=16'hFE01 stable the whole time, req_ready=0. Release res_ready -> op_count=1, req_ready=1 next cycle.
3. DIV a=200, b=7 -> res_valid exactly 9 cycles after accept, res_data={8'd4, 8'd28}. DIV a=5, b=0 -> 1-cycle latency, res_data=0, res_err=1, res_zero=1.
4. Compares: SUB a=3, b=5 -> 16'h00FE. GT a=9, b=3 -> 16'h0001. LT a=9, b=3 -> 16'h0000 with res_zero=1. Opcode 7 -> res_err=1.
5. Assert rst in DIV iteration 4 -> next cycle IDLE, res_valid=0. A following DIV a=100, b=10 -> {8'd0, 8'd10}, with no leftover state.
6. Run 256 back-to-back ADDs with res_ready tied high -> op_count wraps to 0. Change req_a/req_b while busy -> results still reflect the accepted operands.
